// File: rtl/game_io_pkg.sv
// Shared definitions for the game's board I/O: button index map, channel count
// and the per-channel debounce FSM encoding.
package game_io_pkg;

    localparam int unsigned N_BTN     = 4;
    localparam int unsigned BTN_LEFT  = 0;
    localparam int unsigned BTN_RIGHT = 1;
    localparam int unsigned BTN_JUMP  = 2;
    localparam int unsigned BTN_START = 3;

    // Left/right are the only channels that auto-repeat by default.
    localparam logic [N_BTN-1:0] REPEAT_MASK_DFLT =
        N_BTN'((1 << BTN_LEFT) | (1 << BTN_RIGHT));

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StArmHi = 2'd1,
        StHeld  = 2'd2,
        StArmLo = 2'd3
    } btn_state_e;

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-flop synchroniser, tick-based debounce FSM and an
// optional auto-repeat generator while the button is held.
module btn_debounce_ch
    import game_io_pkg::*;
#(
    parameter int unsigned DEB_TICKS    = 20,
    parameter int unsigned REPEAT_DELAY = 400,
    parameter int unsigned REPEAT_RATE  = 100,
    parameter bit          REPEAT_EN    = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_btn_raw,
    input  logic i_tick,
    input  logic i_enable,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_repeat
);

    localparam int unsigned     DebW      = cnt_width(DEB_TICKS);
    localparam int unsigned     RepW      = cnt_width(REPEAT_DELAY);
    localparam logic [DebW-1:0] DebLast   = DebW'(DEB_TICKS - 1);
    localparam logic [RepW-1:0] RepLast   = RepW'(REPEAT_DELAY - 1);
    localparam logic [RepW-1:0] RepReload = RepW'(REPEAT_DELAY - REPEAT_RATE);

    logic            r_sync1, r_sync2;
    btn_state_e      r_state, w_state_d;
    logic [DebW-1:0] r_deb_cnt, w_deb_cnt_d;
    logic [RepW-1:0] r_rep_cnt, w_rep_cnt_d;
    logic            r_level, r_press, r_release, r_repeat;
    logic            w_level_d, w_press_d, w_release_d, w_repeat_d;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_btn_raw;
            r_sync2 <= r_sync1;
        end
    end

    always_comb begin
        w_state_d   = r_state;
        w_deb_cnt_d = r_deb_cnt;
        w_rep_cnt_d = r_rep_cnt;
        w_level_d   = r_level;
        w_press_d   = 1'b0;
        w_release_d = 1'b0;
        w_repeat_d  = 1'b0;
        unique case (r_state)
            StIdle: begin
                w_deb_cnt_d = '0;
                w_rep_cnt_d = '0;
                if (r_sync2) w_state_d = StArmHi;
            end
            StArmHi: begin
                if (!r_sync2) begin
                    w_state_d   = StIdle;
                    w_deb_cnt_d = '0;
                end else if (i_tick) begin
                    if (r_deb_cnt == DebLast) begin
                        w_state_d   = StHeld;
                        w_deb_cnt_d = '0;
                        w_rep_cnt_d = '0;
                        w_level_d   = 1'b1;
                        w_press_d   = i_enable;
                    end else begin
                        w_deb_cnt_d = r_deb_cnt + 1'b1;
                    end
                end
            end
            StHeld: begin
                w_deb_cnt_d = '0;
                if (!r_sync2) begin
                    w_state_d = StArmLo;
                end else if (REPEAT_EN && i_tick) begin
                    // After the first repeat, reload so the next one lands REPEAT_RATE ticks on.
                    if (r_rep_cnt == RepLast) begin
                        w_rep_cnt_d = RepReload;
                        w_repeat_d  = i_enable;
                    end else begin
                        w_rep_cnt_d = r_rep_cnt + 1'b1;
                    end
                end
            end
            StArmLo: begin
                if (r_sync2) begin
                    w_state_d   = StHeld;
                    w_deb_cnt_d = '0;
                end else if (i_tick) begin
                    if (r_deb_cnt == DebLast) begin
                        w_state_d   = StIdle;
                        w_deb_cnt_d = '0;
                        w_rep_cnt_d = '0;
                        w_level_d   = 1'b0;
                        w_release_d = i_enable;
                    end else begin
                        w_deb_cnt_d = r_deb_cnt + 1'b1;
                    end
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= StIdle;
            r_deb_cnt <= '0;
            r_rep_cnt <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_repeat  <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_deb_cnt <= w_deb_cnt_d;
            r_rep_cnt <= w_rep_cnt_d;
            r_level   <= w_level_d;
            r_press   <= w_press_d;
            r_release <= w_release_d;
            r_repeat  <= w_repeat_d;
        end
    end

    assign o_level   = r_level;
    assign o_press   = r_press;
    assign o_release = r_release;
    assign o_repeat  = r_repeat;

endmodule

// File: rtl/btn_input_ctrl.sv
// Player-input front end: shared sample-tick divider feeding one debounce
// channel per button.
module btn_input_ctrl
    import game_io_pkg::*;
#(
    parameter int unsigned       TICK_DIV     = 25000,
    parameter int unsigned       DEB_TICKS    = 20,
    parameter logic [N_BTN-1:0]  REPEAT_MASK  = REPEAT_MASK_DFLT,
    parameter int unsigned       REPEAT_DELAY = 400,
    parameter int unsigned       REPEAT_RATE  = 100
) (
    input  logic             clk_25mhz,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn_raw,
    input  logic             enable,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_repeat
);

    localparam int unsigned      TickW    = cnt_width(TICK_DIV);
    localparam logic [TickW-1:0] TickLast = TickW'(TICK_DIV - 1);

    logic [TickW-1:0] r_tick_cnt;
    logic             r_tick;

    // Tick is registered so it fires on the wrap, not in the first cycle after reset.
    always_ff @(posedge clk_25mhz or negedge rst_n) begin
        if (!rst_n) begin
            r_tick_cnt <= '0;
            r_tick     <= 1'b0;
        end else begin
            r_tick     <= (r_tick_cnt == TickLast);
            r_tick_cnt <= (r_tick_cnt == TickLast) ? '0 : r_tick_cnt + 1'b1;
        end
    end

    for (genvar g = 0; g < N_BTN; g++) begin : g_ch
        btn_debounce_ch #(
            .DEB_TICKS    (DEB_TICKS),
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_RATE  (REPEAT_RATE),
            .REPEAT_EN    (REPEAT_MASK[g])
        ) u_ch (
            .i_clk     (clk_25mhz),
            .i_rst_n   (rst_n),
            .i_btn_raw (btn_raw[g]),
            .i_tick    (r_tick),
            .i_enable  (enable),
            .o_level   (btn_level[g]),
            .o_press   (btn_press[g]),
            .o_release (btn_release[g]),
            .o_repeat  (btn_repeat[g])
        );
    end

endmodule

// File: tb/tb_btn_input_ctrl.sv
// Bench for btn_input_ctrl: directed scenarios plus random button traffic,
// every cycle compared against a tick-counting reference model.
module tb_btn_input_ctrl;
    import game_io_pkg::*;

    localparam int unsigned TD   = 4;
    localparam int unsigned DT   = 3;
    localparam int unsigned RD   = 4;
    localparam int unsigned RR   = 2;
    localparam logic [3:0]  MASK = 4'b0011;

    logic       clk_25mhz = 1'b0;
    logic       rst_n     = 1'b0;
    logic [3:0] btn_raw   = 4'b0000;
    logic       enable    = 1'b1;
    logic [3:0] btn_level, btn_press, btn_release, btn_repeat;

    btn_input_ctrl #(
        .TICK_DIV     (TD),
        .DEB_TICKS    (DT),
        .REPEAT_MASK  (MASK),
        .REPEAT_DELAY (RD),
        .REPEAT_RATE  (RR)
    ) dut (
        .clk_25mhz   (clk_25mhz),
        .rst_n       (rst_n),
        .btn_raw     (btn_raw),
        .enable      (enable),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .btn_repeat  (btn_repeat)
    );

    always #5 clk_25mhz = ~clk_25mhz;

    int vectors     = 0;
    int miscompares = 0;
    int cyc_idx     = 0;

    // Reference model: raw delayed two cycles; level flips after DT ticks during
    // which the synced input continuously disagreed with it.
    logic [3:0] m_s1, m_s2, m_sp, m_lvl, m_press, m_rel, m_rep;
    int         m_cnt[4];
    int         m_hc[4];
    int         m_cyc;

    int         n_press[4], n_rel[4], n_rep[4], rise_at[4];
    int         rep_q[$];
    logic [3:0] prev_lvl = 4'b0000;

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_sp = '0; m_lvl = '0;
        m_press = '0; m_rel = '0; m_rep = '0; m_cyc = 0;
        for (int i = 0; i < 4; i++) begin
            m_cnt[i] = 0;
            m_hc[i]  = 0;
        end
    endtask

    task automatic model_step();
        bit tick_pre;
        tick_pre = (m_cyc > 0) && (m_cyc % TD == 0);
        m_press = '0; m_rel = '0; m_rep = '0;
        for (int i = 0; i < 4; i++) begin
            if (m_sp[i] != m_lvl[i]) begin
                if (m_s2[i] == m_lvl[i]) begin
                    m_cnt[i] = 0;
                end else if (tick_pre) begin
                    m_cnt[i]++;
                    if (m_cnt[i] == DT) begin
                        m_cnt[i] = 0;
                        m_lvl[i] = ~m_lvl[i];
                        m_hc[i]  = 0;
                        if (enable) begin
                            if (m_lvl[i]) m_press[i] = 1'b1;
                            else          m_rel[i]   = 1'b1;
                        end
                    end
                end
            end else begin
                m_cnt[i] = 0;
                if (m_lvl[i] && m_s2[i] && tick_pre && MASK[i]) begin
                    m_hc[i]++;
                    if (m_hc[i] >= RD && (m_hc[i] - RD) % RR == 0 && enable) m_rep[i] = 1'b1;
                end
            end
        end
        m_sp = m_s2;
        m_s2 = m_s1;
        m_s1 = btn_raw;
        m_cyc++;
    endtask

    task automatic check_outputs(input string tag);
        for (int i = 0; i < 4; i++) begin
            vectors++;
            assert (btn_level[i] === m_lvl[i]) else begin
                miscompares++;
                $error("FAIL %s level[%0d] observed=%b expected=%b", tag, i, btn_level[i], m_lvl[i]);
            end
            vectors++;
            assert (btn_press[i] === m_press[i]) else begin
                miscompares++;
                $error("FAIL %s press[%0d] observed=%b expected=%b", tag, i, btn_press[i], m_press[i]);
            end
            vectors++;
            assert (btn_release[i] === m_rel[i]) else begin
                miscompares++;
                $error("FAIL %s release[%0d] observed=%b expected=%b", tag, i, btn_release[i],
                       m_rel[i]);
            end
            vectors++;
            assert (btn_repeat[i] === m_rep[i]) else begin
                miscompares++;
                $error("FAIL %s repeat[%0d] observed=%b expected=%b", tag, i, btn_repeat[i], m_rep[i]);
            end
        end
    endtask

    task automatic chk_range(input string tag, input int obs, input int lo, input int hi);
        vectors++;
        assert (obs >= lo && obs <= hi) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic clear_stats();
        for (int i = 0; i < 4; i++) begin
            n_press[i] = 0; n_rel[i] = 0; n_rep[i] = 0; rise_at[i] = -1000;
        end
        rep_q.delete();
    endtask

    task automatic cycle(input string tag);
        @(posedge clk_25mhz);
        if (rst_n) model_step();
        else       model_reset();
        cyc_idx++;
        #1;
        check_outputs(tag);
        for (int i = 0; i < 4; i++) begin
            n_press[i] += btn_press[i]   ? 1 : 0;
            n_rel[i]   += btn_release[i] ? 1 : 0;
            n_rep[i]   += btn_repeat[i]  ? 1 : 0;
            if (btn_level[i] && !prev_lvl[i]) rise_at[i] = cyc_idx;
        end
        if (btn_repeat[0]) rep_q.push_back(cyc_idx);
        prev_lvl = btn_level;
    endtask

    task automatic run(input int n, input string tag);
        repeat (n) cycle(tag);
    endtask

    initial begin
        int edge_at, r0, r1, reps_before;
        model_reset();
        clear_stats();

        run(3, "reset");
        rst_n = 1'b1;

        clear_stats();
        run(100, "idle");
        chk_range("idle_pulses", n_press[0] + n_press[1] + n_press[2] + n_press[3]
                  + n_rel[0] + n_rel[1] + n_rel[2] + n_rel[3], 0, 0);
        chk_range("idle_level", int'(btn_level), 0, 0);

        // Clean press on the unmasked jump button.
        clear_stats();
        edge_at = cyc_idx;
        btn_raw = 4'b0100;
        run(200, "press_ch2");
        chk_range("ch2_latency", rise_at[2] - edge_at, 12, 15);
        chk_range("ch2_press_cnt", n_press[2], 1, 1);
        chk_range("ch2_no_repeat", n_rep[2], 0, 0);
        btn_raw = 4'b0000;
        run(40, "release_ch2");
        chk_range("ch2_release_cnt", n_rel[2], 1, 1);

        // Bouncy press: three-cycle chatter must not be accepted.
        clear_stats();
        btn_raw[2] = 1'b1; run(3, "bounce");
        btn_raw[2] = 1'b0; run(3, "bounce");
        btn_raw[2] = 1'b1; run(3, "bounce");
        btn_raw[2] = 1'b0; run(3, "bounce");
        edge_at = cyc_idx;
        btn_raw[2] = 1'b1;
        run(60, "bounce_settle");
        chk_range("bounce_press_cnt", n_press[2], 1, 1);
        chk_range("bounce_release_cnt", n_rel[2], 0, 0);
        chk_range("bounce_latency", rise_at[2] - edge_at, 12, 15);
        btn_raw = 4'b0000;
        run(40, "bounce_release");

        // Auto-repeat on the left button.
        clear_stats();
        btn_raw = 4'b0001;
        run(60, "hold_ch0");
        chk_range("rep_count", rep_q.size(), 2, 10);
        r0 = (rep_q.size() > 0) ? rep_q[0] : -1000;
        r1 = (rep_q.size() > 1) ? rep_q[1] : -1000;
        chk_range("rep_first_delay", r0 - rise_at[0], 16, 16);
        chk_range("rep_period", r1 - r0, 8, 8);
        btn_raw = 4'b0000;
        run(3, "release_ch0");
        reps_before = n_rep[0];
        run(40, "release_ch0");
        chk_range("rep_after_release", n_rep[0] - reps_before, 0, 0);
        chk_range("ch0_release_cnt", n_rel[0], 1, 1);

        // Pulses suppressed with enable low; level still tracks.
        clear_stats();
        enable  = 1'b0;
        btn_raw = 4'b0010;
        run(40, "en0_hold");
        chk_range("en0_level_hi", int'(btn_level[1]), 1, 1);
        btn_raw = 4'b0000;
        run(40, "en0_release");
        chk_range("en0_level_lo", int'(btn_level[1]), 0, 0);
        chk_range("en0_pulses", n_press[1] + n_rel[1] + n_rep[1], 0, 0);
        btn_raw = 4'b0010;
        run(30, "en_mid_hold");
        enable = 1'b1;
        run(40, "en_mid_hold");
        chk_range("en_raise_no_press", n_press[1], 0, 0);
        btn_raw = 4'b0000;
        run(40, "en_mid_release");
        chk_range("en_release_cnt", n_rel[1], 1, 1);

        // Reset during debounce with the button held through reset release.
        btn_raw = 4'b1000;
        run(6, "arm_ch3");
        rst_n = 1'b0;
        model_reset();
        #1;
        check_outputs("rst_async");
        chk_range("rst_outputs_zero", int'({btn_level, btn_press, btn_release, btn_repeat}), 0, 0);
        run(5, "in_reset");
        rst_n = 1'b1;
        clear_stats();
        edge_at = cyc_idx;
        run(30, "after_reset");
        chk_range("rst_press_cnt", n_press[3], 1, 1);
        chk_range("rst_latency", rise_at[3] - edge_at, 12, 15);
        btn_raw = 4'b0000;
        run(40, "after_reset_release");

        // Random traffic: single-channel toggles, occasional full patterns, enable and reset churn.
        for (int k = 0; k < 150; k++) begin
            if ($urandom_range(0, 3) == 0) btn_raw = 4'($urandom);
            else btn_raw = btn_raw ^ 4'(1 << $urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) enable = ~enable;
            if ($urandom_range(0, 49) == 0) begin
                rst_n = 1'b0;
                model_reset();
                #1;
                check_outputs("rand_rst_async");
                run(2, "rand_reset");
                rst_n = 1'b1;
            end
            run($urandom_range(1, 40), "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/btn_input_ctrl.md
Name: btn_input_ctrl

Overview:
Player-input front end for the game. It is the input-direction counterpart of the LED status outputs. It takes raw, bouncing push-button levels from the board and synchronises and debounces each one. For each button it produces a clean level, a one-cycle press pulse, a one-cycle release pulse and an optional auto-repeat pulse, all of which the game-calc logic consumes.

Parameters:
N_BTN, 4, number of button channels (index map in shared package)
TICK_DIV, 25000, clk_25mhz cycles per sample tick (1 kHz at 25 MHz)
DEB_TICKS, 20, consecutive stable ticks required to accept a level change (20 ms)
REPEAT_MASK, 4'b0011, channels with auto-repeat enabled (left/right)
REPEAT_DELAY, 400, ticks held before the first repeat pulse
REPEAT_RATE, 100, ticks between subsequent repeat pulses

Ports:
clk_25mhz  in  1  system clock, 25 MHz
rst_n  in  1  asynchronous active-low reset
btn_raw  in  N_BTN  raw button levels, active-high, asynchronous to clk
enable  in  1  0 = suppress press/release/repeat pulses; levels still tracked
btn_level  out  N_BTN  debounced level per channel
btn_press  out  N_BTN  1-cycle pulse on an accepted 0->1 transition
btn_release  out  N_BTN  1-cycle pulse on an accepted 1->0 transition
btn_repeat  out  N_BTN  1-cycle auto-repeat pulse while held (masked channels only)

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. While rst_n=0: all outputs 0, all counters 0, sync flops 0, every channel FSM in IDLE.
- Synchroniser: 2-flop chain per channel. Debounce logic sees btn_raw delayed by 2 cycles.
- Tick: a shared counter runs 0..TICK_DIV-1. tick=1 for exactly one cycle when the counter wraps to 0. All debounce and repeat counters advance only on tick.
- Channel FSM states: IDLE (level 0), ARM_HI (level 0, counting), HELD (level 1), ARM_LO (level 1, counting).
  - IDLE -> ARM_HI when sync=1. Counter clears.
  - ARM_HI: on each tick with sync=1, counter++. When counter reaches DEB_TICKS-1 on a tick -> HELD.
  - ARM_HI: any cycle with sync=0 -> IDLE. This is a bounce; no pulse.
  - HELD -> ARM_LO when sync=0. ARM_LO mirrors ARM_HI with the polarity inverted, ending in IDLE, and returns to HELD on a bounce.
- Outputs:
  - btn_level is registered and changes in the cycle the FSM enters HELD or IDLE from an ARM state.
  - btn_press/btn_release assert in that same cycle for exactly 1 cycle, gated by enable.
  - Level changes on tick boundaries only. Worst-case latency from a stable raw edge is 2 + DEB_TICKS*TICK_DIV + 1 cycles.
- Repeat: in HELD on masked channels, a tick counter starts at entry.
  - First btn_repeat at REPEAT_DELAY ticks after entry.
  - Then one every REPEAT_RATE ticks.
  - The counter clears on leaving HELD.
  - ARM_LO pauses repeats; a return to HELD resumes without clearing.
  - Unmasked channels: btn_repeat is constantly 0.
- enable=0: pulses are suppressed, not queued. FSM and level behave normally. Raising enable while a button is held does not produce a press.
- Button held through reset release: the FSM starts IDLE and reports a press after the normal debounce time.
- Simultaneous channels: fully independent. Multiple pulses may assert in the same cycle.
- Counter widths: sized with $clog2 of the largest count. No overflow is possible; counters saturate/clear by the FSM rules.

Decomposition:
- Shared package game_io_pkg:
  - Channel indices BTN_LEFT=0, BTN_RIGHT=1, BTN_JUMP=2, BTN_START=3.
  - N_BTN.
  - FSM state encoding constants.
- Sub-module btn_debounce_ch: one channel containing the sync chain, FSM, debounce counter and repeat counter.
  - It receives tick and enable.
  - The top instantiates N_BTN copies via generate and owns the tick divider.

Test Plan (sim params TICK_DIV=4, DEB_TICKS=3, REPEAT_DELAY=4, REPEAT_RATE=2):
- Reset then btn_raw=0 for 100 cycles -> all outputs 0 throughout. Tick seen every 4 cycles.
- Clean press on ch2 held 200 cycles -> btn_level[2] rises ≤ 2+12+1 cycles after the edge. btn_press[2]=1 for exactly 1 cycle. btn_repeat[2] stays 0 (unmasked).
- Press ch2 with bounces 1,0,1,0 at 3-cycle spacing, then stable 1 -> exactly one btn_press[2], counted from the last bounce. No release pulse.
- Hold ch0 60 cycles -> btn_repeat[0] first at 4 ticks (16 cycles) after level rise, then every 8 cycles. Release -> one btn_release[0], no further repeats.
- enable=0 during ch1 press and release -> btn_level[1] tracks, zero pulses. Set enable=1 mid-hold -> no press pulse.
- Assert rst_n=0 mid-ARM_HI on ch3, release reset with button still held -> outputs 0 during reset. Press reported 2+12+1 cycles after reset release.
